// File: rtl/layer_link_buffer_pkg.sv
// Shared word/vector geometry for the layer pipeline and the ping-pong bank selector type.
package layer_link_buffer_pkg;

  localparam int unsigned LLB_T    = 12;
  localparam int unsigned LLB_K    = 8;
  localparam int unsigned LLB_LOGK = 3;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/layer_link_buffer_if.sv
// Valid/ready stream link between two layers; slave is the buffer view, master the environment view.
interface layer_link_buffer_if #(
  parameter int unsigned T = layer_link_buffer_pkg::LLB_T
);

  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;
  logic                m_valid;
  logic                m_ready;
  logic signed [T-1:0] data_out;
  logic                m_last;

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out, m_last
  );

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out, m_last
  );

endinterface

// File: rtl/layer_link_buffer_link_bank.sv
// K x T word store: single synchronous write port, combinational read port.
module link_bank
  import layer_link_buffer_pkg::*;
#(
  parameter int unsigned T    = LLB_T,
  parameter int unsigned K    = LLB_K,
  parameter int unsigned LOGK = LLB_LOGK
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [LOGK-1:0]     waddr_i,
  input  logic signed [T-1:0] wdata_i,
  input  logic [LOGK-1:0]     raddr_i,
  output logic signed [T-1:0] rdata_o
);

  logic signed [T-1:0] mem_q [K];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_link_buffer.sv
// Ping-pong vector buffer between layers: one bank fills while the other drains, word order preserved.
module layer_link_buffer
  import layer_link_buffer_pkg::*;
#(
  parameter int unsigned T    = LLB_T,
  parameter int unsigned K    = LLB_K,
  parameter int unsigned LOGK = LLB_LOGK
) (
  input  logic               clk,
  input  logic               reset,
  layer_link_buffer_if.slave lnk
);

  localparam logic [LOGK-1:0] LAST_IDX = LOGK'(K - 1);

  logic [1:0]          full_q, full_d;
  bank_e               wb_q, wb_d;
  bank_e               rb_q, rb_d;
  logic [LOGK-1:0]     wi_q, wi_d;
  logic [LOGK-1:0]     ri_q, ri_d;

  logic                s_ready, m_valid;
  logic                in_fire, out_fire;
  logic signed [T-1:0] rdata0, rdata1, rword;

  assign s_ready  = ~full_q[wb_q];
  assign m_valid  = full_q[rb_q];
  assign in_fire  = lnk.s_valid & s_ready & ~reset;
  assign out_fire = m_valid & lnk.m_ready & ~reset;
  assign rword    = (rb_q == BANK1) ? rdata1 : rdata0;

  assign lnk.s_ready  = s_ready;
  assign lnk.m_valid  = m_valid;
  assign lnk.data_out = m_valid ? rword : '0;
  assign lnk.m_last   = m_valid & (ri_q == LAST_IDX);

  link_bank #(.T(T), .K(K), .LOGK(LOGK)) u_bank0 (
    .clk_i   (clk),
    .we_i    (in_fire & (wb_q == BANK0)),
    .waddr_i (wi_q),
    .wdata_i (lnk.data_in),
    .raddr_i (ri_q),
    .rdata_o (rdata0)
  );

  link_bank #(.T(T), .K(K), .LOGK(LOGK)) u_bank1 (
    .clk_i   (clk),
    .we_i    (in_fire & (wb_q == BANK1)),
    .waddr_i (wi_q),
    .wdata_i (lnk.data_in),
    .raddr_i (ri_q),
    .rdata_o (rdata1)
  );

  // A fill and a drain in one cycle always touch different banks, so both flag edits apply.
  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wi_d   = wi_q;
    ri_d   = ri_q;
    if (in_fire) begin
      if (wi_q == LAST_IDX) begin
        full_d[wb_q] = 1'b1;
        wb_d         = other_bank(wb_q);
        wi_d         = '0;
      end else begin
        wi_d = wi_q + LOGK'(1);
      end
    end
    if (out_fire) begin
      if (ri_q == LAST_IDX) begin
        full_d[rb_q] = 1'b0;
        rb_d         = other_bank(rb_q);
        ri_d         = '0;
      end else begin
        ri_d = ri_q + LOGK'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      wb_q   <= BANK0;
      rb_q   <= BANK0;
      wi_q   <= '0;
      ri_q   <= '0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wi_q   <= wi_d;
      ri_q   <= ri_d;
    end
  end

endmodule

// File: tb/tb_layer_link_buffer.sv
// Directed vector table plus hand-written multi-cycle sequences for the layer link buffer.
module tb_layer_link_buffer;
  import layer_link_buffer_pkg::*;

  localparam int unsigned T    = LLB_T;
  localparam int unsigned K    = LLB_K;
  localparam int unsigned LOGK = LLB_LOGK;

  typedef logic signed [T-1:0] word_t;

  typedef struct {
    logic  sv;
    logic  mr;
    word_t din;
    logic  er;
    logic  ev;
    word_t ed;
    logic  el;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  layer_link_buffer_if #(.T(T)) lnk ();

  layer_link_buffer #(.T(T), .K(K), .LOGK(LOGK)) dut (
    .clk   (clk),
    .reset (reset),
    .lnk   (lnk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic mr, input word_t d);
    @(negedge clk);
    lnk.s_valid = sv;
    lnk.m_ready = mr;
    lnk.data_in = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  task automatic expect_all(input string nm, input logic er, input logic ev, input word_t ed, input logic el);
    chk({nm, ".s_ready"},  lnk.s_ready,  er);
    chk({nm, ".m_valid"},  lnk.m_valid,  ev);
    chk({nm, ".data_out"}, lnk.data_out, ed);
    chk({nm, ".m_last"},   lnk.m_last,   el);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    lnk.s_valid = 1'b0;
    lnk.m_ready = 1'b0;
    lnk.data_in = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    expect_all("reset", 1'b1, 1'b0, '0, 1'b0);
    tick();
  endtask

  vec_t  tbl[$];
  word_t sgn[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    sent;
    int    got;
    logic  in_f;

    lnk.s_valid = 1'b0;
    lnk.m_ready = 1'b0;
    lnk.data_in = '0;

    sgn[0] = word_t'(-2048); sgn[1] = word_t'(2047); sgn[2] = word_t'(-1);  sgn[3] = word_t'(0);
    sgn[4] = word_t'(5);     sgn[5] = word_t'(-5);   sgn[6] = word_t'(100); sgn[7] = word_t'(-100);

    // single vector: fill with m_ready low, wait, hold, drain
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b0, word_t'(i + 1), 1'b1, 1'b0, word_t'(0), 1'b0});
    tbl.push_back('{1'b0, 1'b0, word_t'(0), 1'b1, 1'b1, word_t'(1), 1'b0});
    tbl.push_back('{1'b0, 1'b0, word_t'(0), 1'b1, 1'b1, word_t'(1), 1'b0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 1'b1, word_t'(0), 1'b1, 1'b1, word_t'(i + 1), (i == 7)});
    tbl.push_back('{1'b0, 1'b0, word_t'(0), 1'b1, 1'b0, word_t'(0), 1'b0});
    // sign and range extremes through bank 1
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b0, sgn[i], 1'b1, 1'b0, word_t'(0), 1'b0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 1'b1, word_t'(0), 1'b1, 1'b1, sgn[i], (i == 7)});
    tbl.push_back('{1'b0, 1'b0, word_t'(0), 1'b1, 1'b0, word_t'(0), 1'b0});

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].sv, tbl[i].mr, tbl[i].din);
      expect_all($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ed, tbl[i].el);
      tick();
    end

    // back-pressure: both banks full, 17th word held off
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, word_t'(i + 1));
      chk("bp.fill_ready", lnk.s_ready, 1'b1);
      tick();
    end
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, word_t'(99));
      expect_all("bp.hold", 1'b0, 1'b1, word_t'(1), 1'b0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, '0);
      expect_all("bp.drain", (i >= 8), 1'b1, word_t'(i + 1), (i % 8 == 7));
      tick();
    end
    drive(1'b0, 1'b0, '0);
    expect_all("bp.empty", 1'b1, 1'b0, '0, 1'b0);
    tick();

    // streaming: 40 words with both sides always willing
    do_reset();
    sent = 0;
    got  = 0;
    for (int c = 0; c < 48; c++) begin
      drive(sent < 40, 1'b1, word_t'(100 + sent));
      chk("stream.s_ready", lnk.s_ready, 1'b1);
      in_f = lnk.s_valid & lnk.s_ready;
      if (lnk.m_valid) begin
        chk("stream.data_out", lnk.data_out, word_t'(100 + got));
        chk("stream.m_last", lnk.m_last, (got % 8 == 7));
        got++;
      end
      if (in_f) sent++;
      tick();
    end
    chk("stream.count", got, 40);
    drive(1'b0, 1'b0, '0);
    expect_all("stream.empty", 1'b1, 1'b0, '0, 1'b0);
    tick();

    // simultaneous: last write of bank 1 with last read of bank 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, word_t'(21 + i));
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, word_t'(31 + i));
      chk("sim.fill1_ready", lnk.s_ready, 1'b1);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, '0);
      expect_all("sim.drain0", 1'b1, 1'b1, word_t'(21 + i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, word_t'(38));
    expect_all("sim.edge", 1'b1, 1'b1, word_t'(28), 1'b1);
    tick();
    drive(1'b0, 1'b0, '0);
    expect_all("sim.after", 1'b1, 1'b1, word_t'(31), 1'b0);
    chk("sim.full", dut.full_q, 2'b10);
    chk("sim.rb", dut.rb_q, 1'b1);
    chk("sim.wb", dut.wb_q, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, '0);
      expect_all("sim.drain1", 1'b1, 1'b1, word_t'(31 + i), (i == 7));
      tick();
    end
    drive(1'b0, 1'b0, '0);
    expect_all("sim.empty", 1'b1, 1'b0, '0, 1'b0);
    tick();

    // reset mid-operation, handshakes active during the reset cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, word_t'(1 + i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, word_t'(51 + i));
      chk("rstmid.pre_out", lnk.data_out, word_t'(1 + i));
      tick();
    end
    for (int i = 3; i < 5; i++) begin
      drive(1'b1, 1'b0, word_t'(51 + i));
      tick();
    end
    @(negedge clk);
    reset       = 1'b1;
    lnk.s_valid = 1'b1;
    lnk.m_ready = 1'b1;
    lnk.data_in = word_t'(77);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    expect_all("rstmid.after", 1'b1, 1'b0, '0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, word_t'(11 + i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, '0);
      expect_all("rstmid.drain", 1'b1, 1'b1, word_t'(11 + i), (i == 7));
      tick();
    end
    drive(1'b0, 1'b0, '0);
    expect_all("rstmid.empty", 1'b1, 1'b0, '0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_link_buffer.md
LAYER_LINK_BUFFER -- requirements
Module: layer_link_buffer

Interface
REQ-001 SHALL have parameter T, default 12, meaning signed data word width in bits.
REQ-002 SHALL have parameter K, default 8, meaning words per vector (one layer output vector = one next-layer input vector).
REQ-003 SHALL have parameter LOGK, default 3, meaning ceil(log2(K)), the width of word index counters.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset, input, 1 bit, meaning reset; synchronous, active-high.
REQ-006 SHALL have port s_valid, input, 1 bit, meaning the upstream layer presents a word on data_in.
REQ-007 SHALL have port s_ready, output, 1 bit, meaning the block accepts data_in this cycle.
REQ-008 SHALL have port data_in, input, T bits signed, meaning the upstream layer output word.
REQ-009 SHALL have port m_valid, output, 1 bit, meaning data_out holds a valid word for the downstream layer.
REQ-010 SHALL have port m_ready, input, 1 bit, meaning the downstream layer accepts data_out this cycle.
REQ-011 SHALL have port data_out, output, T bits signed, meaning the word toward the downstream layer.
REQ-012 SHALL have port m_last, output, 1 bit, meaning data_out is word K-1 of the current vector.

Function
REQ-013 SHALL count a transfer only on a posedge with valid and ready both high (either side).
REQ-014 SHALL hold two banks (bank 0, bank 1) of K words each, plus full[1:0], write bank pointer wb, read bank pointer rb, write index wi, read index ri.
REQ-015 SHALL drive s_ready = !full[wb], combinationally.
REQ-016 SHALL, on an input transfer, store data_in at bank[wb][wi] and increment wi.
REQ-017 SHALL, on the input transfer with wi = K-1, set full[wb], toggle wb and clear wi to 0 in the same cycle.
REQ-018 SHALL drive m_valid = full[rb]; data_out = bank[rb][ri] while m_valid is high, else 0.
REQ-019 SHALL drive m_last = m_valid and (ri = K-1).
REQ-020 SHALL, on an output transfer, increment ri; on the transfer with ri = K-1, clear full[rb], toggle rb and clear ri to 0.
REQ-021 SHALL keep data_out, m_last and m_valid stable while m_valid is high and m_ready is low.
REQ-022 SHALL have latency of exactly 1 cycle: m_valid rises on the cycle after the Kth input transfer into an empty buffer.
REQ-023 SHALL output words in arrival order, no reordering, no arithmetic on data (pass-through, bit-exact).
REQ-024 SHALL allow an input and an output transfer in the same cycle, including filling one bank while the final word of the other bank drains; both flag updates take effect.
REQ-025 SHALL deassert s_ready when both banks are full; no input is lost or overwritten.
REQ-026 SHALL sustain one word per cycle steady-state throughput when s_valid and m_ready are held high.
REQ-027 SHALL not depend on s_valid being asserted continuously; gaps on either side only stall the matching counter.

Reset
REQ-028 SHALL, on reset high at a posedge, clear full[1:0], wb, rb, wi and ri to 0, giving s_ready = 1, m_valid = 0, m_last = 0, data_out = 0 on the following cycle.
REQ-029 SHALL discard any partially written or partially read vector on reset mid-operation; bank contents need not be cleared.
REQ-030 SHALL ignore s_valid and m_ready during a cycle in which reset is high.

Structure
REQ-031 SHALL place default T, K and LOGK constants in a shared package used by this block and the layer modules.
REQ-032 SHALL use one sub-module, link_bank: a K x T register array with a one-port synchronous write and a combinational read, instantiated twice.
REQ-033 SHALL keep handshake control (pointers, indices, full flags) in the top module only.

Verification
REQ-034 SHALL cover single vector: after reset, send 1..8 with m_ready = 0 -> s_ready stays 1, m_valid rises 1 cycle after word 8; then m_ready = 1 -> out 1..8, m_last with 8.
REQ-035 SHALL cover back-pressure: both banks full (16 words sent, m_ready = 0) -> s_ready = 0, a 17th word is held off, data_out = first word, stable.
REQ-036 SHALL cover streaming: s_valid = m_ready = 1 for 40 words -> 40 outputs in order, s_ready never drops after the first vector.
REQ-037 SHALL cover simultaneous events: the 8th input of bank 1 and the 8th output of bank 0 in the same cycle -> full = 2'b10, rb = 1, wb = 0, no lost word.
REQ-038 SHALL cover reset mid-operation: reset after 5 inputs and 3 outputs of the prior vector -> next cycle s_ready = 1, m_valid = 0; a new vector 11..18 is output exactly.
REQ-039 SHALL cover sign and range: words -2048, 2047, -1, 0 -> output bit-exact.
